// File: rtl/fifo_rx_word_packer_if.sv
// Bundle of the FIFO read port and the packed-word valid/ready port.
interface fifo_rx_word_packer_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned PACK   = 4,
  parameter int unsigned CNT_W  = 3
);
  logic                     fifo_empty;
  logic [DATA_W-1:0]        recv_data;
  logic                     read_enable;
  logic                     flush;
  logic [DATA_W*PACK-1:0]   word_data;
  logic [CNT_W-1:0]         word_bytes;
  logic                     word_valid;
  logic                     word_ready;

  // Packer side: pops the FIFO and sources packed words.
  modport master (
    input  fifo_empty, recv_data, flush, word_ready,
    output read_enable, word_data, word_bytes, word_valid
  );

  // Environment side: FIFO, flush source and word consumer.
  modport slave (
    output fifo_empty, recv_data, flush, word_ready,
    input  read_enable, word_data, word_bytes, word_valid
  );
endinterface

// File: rtl/fifo_rx_word_packer.sv
// Drains bytes from a first-word-fall-through FIFO and packs them little-endian into
// PACK-byte words on a valid/ready port. Partial words leave on flush or idle timeout.
module fifo_rx_word_packer #(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned PACK        = 4,
  parameter int unsigned CNT_W       = 3,
  parameter int unsigned TIMEOUT_CYC = 64
) (
  input logic                   recv_clk,
  input logic                   recv_rst,
  fifo_rx_word_packer_if.master bus
);
  localparam int unsigned WORD_W = DATA_W * PACK;
  localparam int unsigned IDLE_W = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [CNT_W-1:0]  PACK_CNT = CNT_W'(PACK);
  localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(TIMEOUT_CYC);

  typedef enum logic [1:0] {StEmpty, StFill, StDrain} state_e;

  state_e              state_q, state_d;
  logic [WORD_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]    acc_cnt_q, acc_cnt_d;
  logic [WORD_W-1:0]   word_data_q, word_data_d;
  logic [CNT_W-1:0]    word_bytes_q, word_bytes_d;
  logic                word_valid_q, word_valid_d;
  logic                flush_pend_q, flush_pend_d;
  logic [IDLE_W-1:0]   idle_cnt_q, idle_cnt_d;

  logic                slot_free;
  logic                xfer;
  logic                pop;
  logic                timeout_hit;
  logic [CNT_W-1:0]    lane;
  logic [WORD_W-1:0]   lane_mask;

  // Handshake qualifiers: a sealed word moves to the output whenever the slot is free,
  // and the FIFO may be popped into the lane that frees up in the same cycle.
  always_comb begin
    slot_free   = ~word_valid_q | bus.word_ready;
    xfer        = (state_q == StDrain) & slot_free;
    pop         = ~recv_rst & ~bus.fifo_empty & ((acc_cnt_q < PACK_CNT) | xfer);
    timeout_hit = (TIMEOUT_CYC != 0) && (idle_cnt_q == IDLE_MAX);
  end

  // FSM state register.
  always_ff @(posedge recv_clk or posedge recv_rst) begin
    if (recv_rst) begin
      state_q <= StEmpty;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state; the fill-to-drain check looks at the post-pop count so a full
  // word is sealed in the cycle after its last byte is popped.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StEmpty: if (pop) state_d = StFill;
      StFill: begin
        if ((acc_cnt_d == PACK_CNT) || flush_pend_q || timeout_hit) state_d = StDrain;
      end
      StDrain: if (xfer) state_d = pop ? StFill : StEmpty;
      default: state_d = StEmpty;
    endcase
  end

  // FSM/port outputs.
  always_comb begin
    bus.read_enable = pop;
    bus.word_data   = word_data_q;
    bus.word_bytes  = word_bytes_q;
    bus.word_valid  = word_valid_q;
  end

  // Datapath next state: accumulator, output word, flush request and idle counter.
  always_comb begin
    acc_d        = acc_q;
    acc_cnt_d    = acc_cnt_q;
    word_data_d  = word_data_q;
    word_bytes_d = word_bytes_q;
    word_valid_d = word_valid_q;
    flush_pend_d = flush_pend_q;
    idle_cnt_d   = idle_cnt_q;
    lane         = xfer ? '0 : acc_cnt_q;
    lane_mask    = '0;

    // Stale bytes from the previous word linger in the upper lanes; mask them off.
    for (int k = 0; k < int'(PACK); k++) begin
      if (CNT_W'(k) < acc_cnt_q) lane_mask[k*DATA_W +: DATA_W] = '1;
    end

    if (xfer) begin
      word_data_d  = acc_q & lane_mask;
      word_bytes_d = acc_cnt_q;
      word_valid_d = 1'b1;
      acc_cnt_d    = pop ? CNT_W'(1) : '0;
    end else if (word_valid_q & bus.word_ready) begin
      word_valid_d = 1'b0;
    end

    if (pop) begin
      for (int k = 0; k < int'(PACK); k++) begin
        if (lane == CNT_W'(k)) acc_d[k*DATA_W +: DATA_W] = bus.recv_data;
      end
      if (!xfer) acc_cnt_d = acc_cnt_q + CNT_W'(1);
    end

    // A flush seen while draining is covered by the transfer already pending.
    if (xfer) begin
      flush_pend_d = 1'b0;
    end else if (bus.flush && (state_q != StDrain) && ((acc_cnt_q != '0) || pop)) begin
      flush_pend_d = 1'b1;
    end

    if (pop || xfer) begin
      idle_cnt_d = '0;
    end else if ((state_q == StFill) && (idle_cnt_q != IDLE_MAX)) begin
      idle_cnt_d = idle_cnt_q + IDLE_W'(1);
    end
  end

  // Datapath registers.
  always_ff @(posedge recv_clk or posedge recv_rst) begin
    if (recv_rst) begin
      acc_q        <= '0;
      acc_cnt_q    <= '0;
      word_data_q  <= '0;
      word_bytes_q <= '0;
      word_valid_q <= 1'b0;
      flush_pend_q <= 1'b0;
      idle_cnt_q   <= '0;
    end else begin
      acc_q        <= acc_d;
      acc_cnt_q    <= acc_cnt_d;
      word_data_q  <= word_data_d;
      word_bytes_q <= word_bytes_d;
      word_valid_q <= word_valid_d;
      flush_pend_q <= flush_pend_d;
      idle_cnt_q   <= idle_cnt_d;
    end
  end
endmodule

// File: tb/tb_fifo_rx_word_packer.sv
// Randomized and directed bench for fifo_rx_word_packer against a queue-based model.
module tb_fifo_rx_word_packer;
  localparam int unsigned PACK = 4;
  localparam int unsigned TMO  = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fifo_rx_word_packer_if #(.DATA_W(8), .PACK(4), .CNT_W(3)) bus ();
  fifo_rx_word_packer_if #(.DATA_W(8), .PACK(4), .CNT_W(3)) bus2 ();

  fifo_rx_word_packer #(.DATA_W(8), .PACK(4), .CNT_W(3), .TIMEOUT_CYC(TMO)) dut (
    .recv_clk (clk),
    .recv_rst (rst),
    .bus      (bus)
  );

  fifo_rx_word_packer #(.DATA_W(8), .PACK(4), .CNT_W(3), .TIMEOUT_CYC(0)) dut_no_tmo (
    .recv_clk (clk),
    .recv_rst (rst),
    .bus      (bus2)
  );

  int n_checks = 0;
  int n_errors = 0;
  int n_pops   = 0;

  // Environment state.
  logic [7:0]  fifo_q[$];
  logic [7:0]  sent_q[$];
  logic [7:0]  got_q[$];
  logic [31:0] got_w[$];
  int          got_b[$];

  // Reference model: bytes collected for the next word, whether that word is sealed,
  // and the output register contents.
  logic [7:0]  m_acc[$];
  bit          m_drain, m_fp, m_valid;
  int          m_idle, m_bytes;
  logic [31:0] m_word;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic push_byte(input logic [7:0] b);
    fifo_q.push_back(b);
    sent_q.push_back(b);
  endtask

  task automatic model_reset();
    m_acc.delete();
    m_drain = 0; m_fp = 0; m_valid = 0;
    m_idle = 0; m_bytes = 0; m_word = '0;
  endtask

  task automatic model_step(input bit fe, input logic [7:0] rd, input bit fl, input bit wr,
                            output bit pop);
    bit slot_free, xfer, hit, fill, nfp, ndrain;
    int nidle;
    slot_free = !m_valid || wr;
    xfer      = m_drain && slot_free;
    pop       = !fe && ((m_acc.size() < PACK) || xfer);
    hit       = (TMO != 0) && (m_idle == TMO);
    fill      = !m_drain && (m_acc.size() > 0);
    if (xfer) nfp = 0;
    else nfp = m_fp || (fl && !m_drain && ((m_acc.size() > 0) || pop));
    if (pop || xfer) nidle = 0;
    else if (fill && m_idle < TMO) nidle = m_idle + 1;
    else nidle = m_idle;
    if (m_drain) ndrain = !xfer;
    else if (fill) ndrain = ((m_acc.size() + (pop ? 1 : 0)) == PACK) || m_fp || hit;
    else ndrain = 0;
    if (xfer) begin
      m_word = '0;
      foreach (m_acc[k]) m_word[k*8 +: 8] = m_acc[k];
      m_bytes = m_acc.size();
      m_valid = 1;
      m_acc.delete();
    end else if (m_valid && wr) begin
      m_valid = 0;
    end
    if (pop) m_acc.push_back(rd);
    m_drain = ndrain; m_fp = nfp; m_idle = nidle;
  endtask

  // One clock: entered and left at posedge+1.
  task automatic cycle(input bit fl, input bit wr, input bit gate);
    bit fe, pop;
    logic [7:0] rd;
    check("word_valid", 64'(bus.word_valid), 64'(m_valid));
    check("word_data", 64'(bus.word_data), 64'(m_word));
    check("word_bytes", 64'(bus.word_bytes), 64'(m_bytes));
    fe = gate || (fifo_q.size() == 0);
    rd = (fifo_q.size() != 0) ? fifo_q[0] : 8'h00;
    bus.fifo_empty = fe;
    bus.recv_data  = rd;
    bus.flush      = fl;
    bus.word_ready = wr;
    #1;
    if (bus.word_valid && wr) begin
      got_w.push_back(bus.word_data);
      got_b.push_back(int'(bus.word_bytes));
      for (int k = 0; k < int'(bus.word_bytes); k++) got_q.push_back(bus.word_data[k*8 +: 8]);
    end
    model_step(fe, rd, fl, wr, pop);
    check("read_enable", 64'(bus.read_enable), 64'(pop));
    if (bus.read_enable && !fe) begin
      n_pops++;
      void'(fifo_q.pop_front());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    check("rst_word_valid", 64'(bus.word_valid), 64'(0));
    check("rst_read_enable", 64'(bus.read_enable), 64'(0));
    check("rst_word_data", 64'(bus.word_data), 64'(0));
    check("rst_word_bytes", 64'(bus.word_bytes), 64'(0));
    bus.fifo_empty = 1'b1; bus.flush = 1'b0; bus.word_ready = 1'b0; bus.recv_data = '0;
    fifo_q.delete(); sent_q.delete(); got_q.delete(); got_w.delete(); got_b.delete();
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    int first_v, last_pop, bad;
    bit seen;
    bus.fifo_empty = 1'b0; bus.flush = 1'b0; bus.word_ready = 1'b0; bus.recv_data = 8'h5A;
    bus2.fifo_empty = 1'b1; bus2.flush = 1'b0; bus2.word_ready = 1'b1; bus2.recv_data = '0;
    @(posedge clk);
    #1;
    do_reset();

    // Full-rate stream of two words.
    for (int b = 1; b <= 8; b++) push_byte(8'(b * 17));
    n_pops = 0;
    for (int i = 0; i < 8; i++) cycle(0, 1, 0);
    check("t1_back_to_back_pops", 64'(n_pops), 64'(8));
    for (int i = 0; i < 4; i++) cycle(0, 1, 0);
    check("t1_word_count", 64'(got_w.size()), 64'(2));
    if (got_w.size() == 2) begin
      check("t1_word0", 64'(got_w[0]), 64'h44332211);
      check("t1_word1", 64'(got_w[1]), 64'h88776655);
      check("t1_bytes0", 64'(got_b[0]), 64'(4));
      check("t1_bytes1", 64'(got_b[1]), 64'(4));
    end

    // Backpressure: first word held, accumulator fills behind it, then release.
    do_reset();
    for (int b = 1; b <= 12; b++) push_byte(8'(b));
    n_pops = 0;
    for (int i = 0; i < 12; i++) cycle(0, 0, 0);
    check("t2_pops_while_blocked", 64'(n_pops), 64'(8));
    check("t2_held_valid", 64'(bus.word_valid), 64'(1));
    check("t2_held_data", 64'(bus.word_data), 64'h04030201);
    check("t2_read_enable_low", 64'(bus.read_enable), 64'(0));
    for (int i = 0; i < 16; i++) cycle(0, 1, 0);
    check("t2_word_count", 64'(got_w.size()), 64'(3));
    if (got_w.size() == 3) begin
      check("t2_word0", 64'(got_w[0]), 64'h04030201);
      check("t2_word1", 64'(got_w[1]), 64'h08070605);
      check("t2_word2", 64'(got_w[2]), 64'h0C0B0A09);
    end

    // Explicit flush of a 2-byte partial, then flush coinciding with a pop.
    do_reset();
    push_byte(8'hAA); push_byte(8'hBB);
    for (int i = 0; i < 3; i++) cycle(0, 1, 0);
    cycle(1, 1, 0);
    for (int i = 0; i < 6; i++) cycle(0, 1, 0);
    push_byte(8'hCC);
    cycle(1, 1, 0);
    for (int i = 0; i < 6; i++) cycle(0, 1, 0);
    check("t3_word_count", 64'(got_w.size()), 64'(2));
    if (got_w.size() == 2) begin
      check("t3_partial_data", 64'(got_w[0]), 64'h0000BBAA);
      check("t3_partial_bytes", 64'(got_b[0]), 64'(2));
      check("t3_lane0_data", 64'(got_w[1]), 64'h000000CC);
      check("t3_lane0_bytes", 64'(got_b[1]), 64'(1));
    end

    // Idle timeout: word appears TMO+3 cycles after the last pop
    // (TMO idle cycles to saturate, one to seal, one to transfer, one to register).
    do_reset();
    push_byte(8'h31); push_byte(8'h32); push_byte(8'h33);
    first_v = -1; last_pop = -1;
    for (int i = 0; i < 30; i++) begin
      if (bus.word_valid && first_v < 0) first_v = i;
      n_pops = 0;
      cycle(0, 1, 0);
      if (n_pops != 0) last_pop = i;
    end
    check("t4_timeout_gap", 64'(first_v - last_pop), 64'(TMO + 3));
    check("t4_word_count", 64'(got_w.size()), 64'(1));
    if (got_w.size() == 1) begin
      check("t4_bytes", 64'(got_b[0]), 64'(3));
      check("t4_data", 64'(got_w[0]), 64'h00333231);
    end

    // Timeout disabled: partial sits until flushed.
    for (int b = 0; b < 3; b++) begin
      bus2.fifo_empty = 1'b0;
      bus2.recv_data  = 8'(8'hC1 + b);
      #1;
      check("t4b_pop", 64'(bus2.read_enable), 64'(1));
      cycle(0, 1, 0);
    end
    bus2.fifo_empty = 1'b1;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus2.word_valid) seen = 1;
      cycle(0, 1, 0);
    end
    check("t4b_no_timeout_word", 64'(seen), 64'(0));
    bus2.flush = 1'b1;
    cycle(0, 1, 0);
    bus2.flush = 1'b0;
    seen = 0;
    for (int i = 0; i < 8 && !seen; i++) begin
      if (bus2.word_valid) seen = 1;
      else cycle(0, 1, 0);
    end
    check("t4b_flushed_seen", 64'(seen), 64'(1));
    check("t4b_flushed_bytes", 64'(bus2.word_bytes), 64'(3));
    check("t4b_flushed_data", 64'(bus2.word_data), 64'h00C3C2C1);

    // Flush with nothing accumulated is ignored.
    do_reset();
    cycle(1, 1, 0);
    for (int i = 0; i < 8; i++) cycle(0, 1, 0);
    check("t5_no_empty_word", 64'(got_w.size()), 64'(0));
    check("t5_valid_low", 64'(bus.word_valid), 64'(0));

    // Reset mid-word, then a clean word afterwards.
    do_reset();
    for (int b = 0; b < 4; b++) push_byte(8'(8'h50 + b));
    cycle(0, 1, 0);
    cycle(0, 1, 0);
    do_reset();
    for (int b = 0; b < 4; b++) push_byte(8'(8'hE1 + b));
    for (int i = 0; i < 10; i++) cycle(0, 1, 0);
    check("t6_word_count", 64'(got_w.size()), 64'(1));
    if (got_w.size() == 1) check("t6_word", 64'(got_w[0]), 64'hE4E3E2E1);

    // Random traffic, flushes, backpressure and FIFO stalls; then drain and compare order.
    do_reset();
    for (int i = 0; i < 900; i++) begin
      if ((i % 150) < 120 && fifo_q.size() < 32 && $urandom_range(0, 9) < 6)
        push_byte(8'($urandom));
      cycle(($urandom_range(0, 15) == 0), ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 7) == 0));
    end
    for (int i = 0; i < 120; i++) cycle(0, 1, 0);
    check("rand_byte_count", 64'(got_q.size()), 64'(sent_q.size()));
    bad = 0;
    for (int k = 0; k < got_q.size() && k < sent_q.size(); k++)
      if (got_q[k] !== sent_q[k]) bad++;
    check("rand_byte_order", 64'(bad), 64'(0));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
